// File: rtl/controlador_ascensor.sv
// controlador_ascensor: per-car scan-style elevator controller for a 4-floor building.
// Optional macro DOOR_REOPEN_EN: a call at the open floor restarts the door timer.
module controlador_ascensor #(
  parameter int unsigned TRAVEL_CYCLES = 50000000,
  parameter int unsigned DOOR_CYCLES   = 100000000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] solicitud,
  output logic [1:0] piso,
  output logic [1:0] direccion,
  output logic       puertas_abiertas,
  output logic [3:0] pendientes
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVING = 2'd1;
  localparam logic [1:0] ST_DOOR   = 2'd2;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

`ifdef DOOR_REOPEN_EN
  localparam logic REOPEN = 1'b1;
`else
  localparam logic REOPEN = 1'b0;
`endif

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] timer, timer_d;
  logic             last_up, last_up_d;
  logic [1:0]       piso_d, dir_d;
  logic             door_d;
  logic [3:0]       pend_d;

  logic [3:0] req_eff, here_mask, above_mask, below_mask, next_mask;
  logic [1:0] next_floor;
  logic       req_above, req_below, at_limit, going_up;

  // Floor masks relative to the current car position.
  always_comb begin
    req_eff    = pendientes | solicitud;
    here_mask  = 4'b0001 << piso;
    above_mask = 4'b1110 << piso;
    below_mask = ~(4'b1111 << piso);
    req_above  = |(req_eff & above_mask);
    req_below  = |(req_eff & below_mask);
    going_up   = (direccion == DIR_UP);
    next_floor = going_up ? piso + 2'd1 : piso - 2'd1;
    next_mask  = 4'b0001 << next_floor;
    at_limit   = going_up ? (piso == 2'd3) : (piso == 2'd0);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    last_up_d = last_up;
    piso_d    = piso;
    dir_d     = direccion;
    door_d    = puertas_abiertas;
    pend_d    = req_eff;
    case (state)
      ST_IDLE: begin
        if (|(req_eff & here_mask)) begin
          state_d = ST_DOOR;
          door_d  = 1'b1;
          timer_d = '0;
          pend_d  = req_eff & ~here_mask;
        end else if (last_up ? req_above : req_below) begin
          state_d = ST_MOVING;
          timer_d = '0;
          dir_d   = last_up ? DIR_UP : DIR_DOWN;
        end else if (last_up ? req_below : req_above) begin
          state_d   = ST_MOVING;
          timer_d   = '0;
          dir_d     = last_up ? DIR_DOWN : DIR_UP;
          last_up_d = ~last_up;
        end
      end
      ST_MOVING: begin
        timer_d = timer + CNT_W'(1);
        if (timer == TRAVEL_LAST) begin
          timer_d = '0;
          if (at_limit) begin
            state_d = ST_IDLE;
            dir_d   = DIR_STOP;
          end else begin
            piso_d = next_floor;
            if (|(req_eff & next_mask)) begin
              state_d = ST_DOOR;
              dir_d   = DIR_STOP;
              door_d  = 1'b1;
              pend_d  = req_eff & ~next_mask;
            end
          end
        end
      end
      ST_DOOR: begin
        pend_d  = req_eff & ~here_mask;
        timer_d = timer + CNT_W'(1);
        if (timer == DOOR_LAST) begin
          state_d = ST_IDLE;
          door_d  = 1'b0;
          timer_d = '0;
        end
        // A held call at the open floor keeps the doors open.
        if (REOPEN && |(solicitud & here_mask)) begin
          state_d = ST_DOOR;
          door_d  = 1'b1;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        dir_d   = DIR_STOP;
        door_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      timer            <= '0;
      last_up          <= 1'b1;
      piso             <= 2'd0;
      direccion        <= DIR_STOP;
      puertas_abiertas <= 1'b0;
      pendientes       <= 4'b0000;
    end else begin
      state            <= state_d;
      timer            <= timer_d;
      last_up          <= last_up_d;
      piso             <= piso_d;
      direccion        <= dir_d;
      puertas_abiertas <= door_d;
      pendientes       <= pend_d;
    end
  end

endmodule

// File: tb/tb_controlador_ascensor.sv
// Bench for controlador_ascensor: directed scenarios plus random calls against a behavioural model.
`timescale 1ns/1ps
module tb_controlador_ascensor;

  localparam int TRAVEL = 4;
  localparam int DOOR   = 6;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

`ifdef DOOR_REOPEN_EN
  localparam bit REOPEN = 1'b1;
`else
  localparam bit REOPEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] solicitud = 4'b0000;
  logic [1:0] piso, direccion;
  logic       puertas_abiertas;
  logic [3:0] pendientes;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  controlador_ascensor #(
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR),
    .CNT_W        (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .solicitud       (solicitud),
    .piso            (piso),
    .direccion       (direccion),
    .puertas_abiertas(puertas_abiertas),
    .pendientes      (pendientes)
  );

  // Reference model: countdown of cycles left in the current activity, signed direction.
  int         m_floor = 0, m_mode = M_IDLE, m_dir = 0, m_left = 0;
  bit         m_up = 1'b1;
  logic [3:0] m_pend = 4'b0000;
  logic [1:0] e_piso = 2'd0, e_dir = 2'b00;
  logic       e_door = 1'b0;
  logic [3:0] e_pend = 4'b0000;

  always @(posedge clk) begin : model
    logic [3:0] req;
    bit above, below;
    int nf;
    if (!rst_n) begin
      m_floor = 0; m_mode = M_IDLE; m_dir = 0; m_left = 0; m_up = 1'b1; m_pend = 4'b0000;
    end else begin
      req = m_pend | solicitud;
      above = 1'b0;
      below = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (req[j] && j > m_floor) above = 1'b1;
        if (req[j] && j < m_floor) below = 1'b1;
      end
      m_pend = req;
      case (m_mode)
        M_IDLE: begin
          if (req[m_floor]) begin
            m_mode = M_DOOR; m_left = DOOR; m_pend[m_floor] = 1'b0;
          end else if (m_up ? above : below) begin
            m_mode = M_MOVE; m_dir = m_up ? 1 : -1; m_left = TRAVEL;
          end else if (m_up ? below : above) begin
            m_up = !m_up; m_mode = M_MOVE; m_dir = m_up ? 1 : -1; m_left = TRAVEL;
          end
        end
        M_MOVE: begin
          m_left--;
          if (m_left == 0) begin
            nf = m_floor + m_dir;
            m_left = TRAVEL;
            if (nf < 0 || nf > 3) begin
              m_mode = M_IDLE; m_dir = 0;
            end else begin
              m_floor = nf;
              if (req[nf]) begin
                m_mode = M_DOOR; m_dir = 0; m_left = DOOR; m_pend[nf] = 1'b0;
              end
            end
          end
        end
        default: begin
          m_pend[m_floor] = 1'b0;
          m_left--;
          if (REOPEN && solicitud[m_floor]) m_left = DOOR;
          if (m_left == 0) m_mode = M_IDLE;
        end
      endcase
    end
    e_piso = 2'(m_floor);
    e_dir  = (m_mode == M_MOVE) ? ((m_dir > 0) ? 2'b01 : 2'b10) : 2'b00;
    e_door = (m_mode == M_DOOR);
    e_pend = m_pend;
  end

  // Drive one cycle of calls and wait until outputs have settled after the next edge.
  task automatic tick(input logic [3:0] s);
    solicitud = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(4'b0000);
    tick(4'b0000);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    rst_n = 1'b0;
    tick(4'b1111);
    tick(4'b1111);
    got = {piso, direccion, puertas_abiertas, pendientes};
    n_vec++;
    if (got !== 9'b0) begin
      n_err++;
      $display("FAIL reset got=%b want=%b", got, 9'b0);
    end
    rst_n = 1'b1;
    solicitud = 4'b0000;
  endtask

  task automatic test_single_floor();
    logic [8:0] got, want;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick((k == 0) ? 4'b0001 : 4'b0000);
      got  = {piso, direccion, puertas_abiertas, pendientes};
      want = {2'd0, 2'b00, (k < DOOR), 4'b0000};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL single_floor k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  task automatic test_travel();
    logic [8:0] got, want;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      tick((k == 0) ? 4'b1000 : 4'b0000);
      got = {piso, direccion, puertas_abiertas, pendientes};
      if (k < 12) want = {2'(k / 4), 2'b01, 1'b0, 4'b1000};
      else        want = {2'd3, 2'b00, (k < 12 + DOOR), 4'b0000};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL travel k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  task automatic test_stop_on_way();
    logic [8:0] got, want;
    bit chk;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      tick((k == 0) ? 4'b1000 : (k == 1) ? 4'b0010 : 4'b0000);
      chk = 1'b1;
      case (k)
        3:  want = {2'd0, 2'b01, 1'b0, 4'b1010};
        4:  want = {2'd1, 2'b00, 1'b1, 4'b1000};
        9:  want = {2'd1, 2'b00, 1'b1, 4'b1000};
        10: want = {2'd1, 2'b00, 1'b0, 4'b1000};
        11: want = {2'd1, 2'b01, 1'b0, 4'b1000};
        15: want = {2'd2, 2'b01, 1'b0, 4'b1000};
        19: want = {2'd3, 2'b00, 1'b1, 4'b0000};
        default: begin chk = 1'b0; want = '0; end
      endcase
      got = {piso, direccion, puertas_abiertas, pendientes};
      if (chk) begin
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL stop_on_way k=%0d got=%b want=%b", k, got, want);
        end
      end
    end
  endtask

  task automatic test_reverse();
    logic [8:0] got, want;
    bit chk;
    do_reset();
    for (int k = 0; k < 41; k++) begin
      tick((k == 0) ? 4'b0100 : (k == 15) ? 4'b1001 : 4'b0000);
      chk = 1'b1;
      case (k)
        14: want = {2'd2, 2'b00, 1'b0, 4'b0000};
        15: want = {2'd2, 2'b01, 1'b0, 4'b1001};
        19: want = {2'd3, 2'b00, 1'b1, 4'b0001};
        25: want = {2'd3, 2'b00, 1'b0, 4'b0001};
        26: want = {2'd3, 2'b10, 1'b0, 4'b0001};
        30: want = {2'd2, 2'b10, 1'b0, 4'b0001};
        34: want = {2'd1, 2'b10, 1'b0, 4'b0001};
        38: want = {2'd0, 2'b00, 1'b1, 4'b0000};
        default: begin chk = 1'b0; want = '0; end
      endcase
      got = {piso, direccion, puertas_abiertas, pendientes};
      if (chk) begin
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL reverse k=%0d got=%b want=%b", k, got, want);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [8:0] got, want;
    do_reset();
    for (int k = 0; k < 6; k++) tick((k == 0) ? 4'b1000 : 4'b0000);
    got  = {piso, direccion, puertas_abiertas, pendientes};
    want = {2'd1, 2'b01, 1'b0, 4'b1000};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL mid_reset_pre got=%b want=%b", got, want);
    end
    rst_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(4'b0000);
      rst_n = 1'b1;
      got = {piso, direccion, puertas_abiertas, pendientes};
      n_vec++;
      if (got !== 9'b0) begin
        n_err++;
        $display("FAIL mid_reset k=%0d got=%b want=%b", k, got, 9'b0);
      end
    end
  endtask

  task automatic test_door_reopen();
    logic [8:0] got, want;
    int close_k;
    close_k = REOPEN ? 11 + DOOR : 8 + DOOR;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      tick((k == 0 || k == 11) ? 4'b0100 : 4'b0000);
      if (k >= 8) begin
        got  = {piso, direccion, puertas_abiertas, pendientes};
        want = {2'd2, 2'b00, (k < close_k), 4'b0000};
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL door_reopen k=%0d got=%b want=%b", k, got, want);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] got, want;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      tick(($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000);
      got  = {piso, direccion, puertas_abiertas, pendientes};
      want = {e_piso, e_dir, e_door, e_pend};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL random k=%0d got=%b want=%b", k, got, want);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_floor();
    test_travel();
    test_stop_on_way();
    test_reverse();
    test_mid_reset();
    test_door_reopen();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controlador_ascensor.md
Name: controlador_ascensor

Overview:
- Per-car elevator controller for a fixed 4-floor building (floors 0-3). It latches floor call requests and runs a scan-style move/stop/door state machine.
- Drives the car status bus (piso, direccion, puertas_abiertas) consumed by the display and LED controllers.
- Two instances (car 1, car 2) replace the fixed-pattern test stimulus generators in the top level.

Parameters:
- TRAVEL_CYCLES, 50000000: clk cycles to travel one floor. Minimum 2.
- DOOR_CYCLES, 100000000: clk cycles the doors stay open per stop. Minimum 2.
- CNT_W, 27: timer width. Both cycle parameters must be <= 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- solicitud  in  4  floor call requests, one bit per floor. Level-sampled every cycle; a 1-cycle pulse is enough to register a call.
- piso  out  2  current floor, registered.
- direccion  out  2  car motion, registered: 2'b00 stopped, 2'b01 up, 2'b10 down. 2'b11 is never driven.
- puertas_abiertas  out  1  doors open, registered.
- pendientes  out  4  latched, not-yet-served calls (debug/LEDs), registered.

Behaviour:
- Reset: while rst_n=0 at an edge:
  - piso=0, direccion=00, puertas_abiertas=0, pendientes=0.
  - state=IDLE, timer=0, last_dir=up.
  - Reset wins over every other event, including mid-travel and door-open.
- Effective requests: req_eff = pendientes | solicitud. All decisions in a cycle use req_eff, so a call is acted on at the same edge it is sampled.
- States: IDLE, MOVING, DOOR.
- IDLE (direccion=00, puertas_abiertas=0):
  - If req_eff[piso]: go to DOOR, puertas_abiertas=1, timer=0. Bit piso is cleared (never latched).
  - Else if any request exists on the last_dir side: go to MOVING in last_dir.
  - Else if any request exists on the opposite side: go to MOVING opposite, and last_dir flips.
  - Else stay in IDLE.
  - Entering MOVING sets direccion to the move direction and timer=0. Remaining req_eff bits latch into pendientes.
- MOVING:
  - Timer increments each cycle. When timer == TRAVEL_CYCLES-1, piso is incremented (up) or decremented (down) and timer=0.
  - At that same edge: if req_eff[new floor], go to DOOR, direccion=00, puertas_abiertas=1, bit cleared.
  - Otherwise continue in the same direction. The target always lies ahead, because calls cannot be cancelled.
  - Guard: never increment at floor 3 or decrement at floor 0. If that would occur, go to IDLE.
- DOOR (direccion=00, puertas_abiertas=1):
  - Timer increments. When timer == DOOR_CYCLES-1, puertas_abiertas=0 and the FSM goes to IDLE.
  - solicitud[piso] while in DOOR is discarded; it does not set a pending bit. Behaviour under DOOR_REOPEN_EN is given below.
  - Other floors' calls latch normally.
- Latencies:
  - Call at the current floor in IDLE: puertas_abiertas=1 after the sampling edge.
  - Door close to next departure: exactly 1 cycle spent in IDLE.
- Simultaneous events: any number of solicitud bits may be set in one cycle. The direction rule applies; scan order serves all calls along the way.
- pendientes never holds the bit of the floor where the doors are currently open.

Optional Feature:
- Macro: DOOR_REOPEN_EN.
- Defined: solicitud[piso] while in DOOR resets the timer to 0, extending the open time by a full DOOR_CYCLES from that edge. It repeats on every asserted cycle (held button keeps doors open) and never sets a pending bit.
- Undefined: the request is ignored, and the doors close DOOR_CYCLES after opening.

Test Plan (TRAVEL_CYCLES=4, DOOR_CYCLES=6):
1. Reset, then solicitud=4'b0001 for 1 cycle -> puertas_abiertas=1 after that edge for 6 cycles with direccion=00 and piso=0. It then drops to 0 and pendientes stays 0.
2. From IDLE at piso 0, pulse solicitud=4'b1000 -> direccion=01 after the sampling edge.
   - piso reaches 1, 2, 3 at cycles 4, 8, 12.
   - At the edge piso becomes 3: direccion=00, puertas_abiertas=1, pendientes=0.
3. Moving up from 0 toward 3, pulse solicitud=4'b0010 before piso reaches 1 -> stops at floor 1 with doors open for 6 cycles. After 1 IDLE cycle it resumes direccion=01 and stops at floor 3.
4. IDLE at piso 2 with last_dir=up, pulse solicitud=4'b1001 -> serves floor 3 first. It then reverses (direccion=10) and serves floor 0, passing floors 2 and 1 without stopping.
5. Drive rst_n=0 for 1 cycle at piso 1 mid-travel with pendientes=4'b1000 -> after that edge piso=0, direccion=00, puertas_abiertas=0, pendientes=0. The FSM stays in IDLE with no call.
6. Doors open at floor 2, assert solicitud=4'b0100 on door cycle 4:
   - With DOOR_REOPEN_EN: doors close 6 cycles after that edge.
   - Without it: doors close at cycle 6 after opening, and pendientes stays 0 in both builds.
